// File: rtl/lab_nios_system_pio_pkg.sv
// Shared definitions for the lab Nios system parallel I/O peripherals.
// Register offsets of the input PIO slave, edge-type encodings, and a
// helper that sizes the debounce counters.
package lab_nios_system_pio_pkg;

  localparam logic [1:0] ADDR_DATA     = 2'd0;
  localparam logic [1:0] ADDR_RSVD     = 2'd1;
  localparam logic [1:0] ADDR_IRQ_MASK = 2'd2;
  localparam logic [1:0] ADDR_EDGE_CAP = 2'd3;

  localparam int EDGE_FALL = 0;
  localparam int EDGE_RISE = 1;
  localparam int EDGE_ANY  = 2;

  // ceil(log2(cycles+1)), never narrower than one bit so that the
  // bypass configuration still elaborates a legal vector type.
  function automatic int cnt_width(input int cycles);
    return (cycles < 1) ? 1 : $clog2(cycles + 1);
  endfunction

endpackage

// File: rtl/lab_nios_system_pio_debounce.sv
// Single-bit input conditioner: two-flop synchroniser followed by a
// counter-based debounce filter.
//   clk      system clock
//   reset_n  asynchronous active-low reset
//   pin_in   raw asynchronous pin
//   deb_out  synchronised, debounced level
// With DEBOUNCE_CYCLES = 0 the filter is removed and deb_out is the
// second synchroniser stage.
module lab_nios_system_pio_debounce
  import lab_nios_system_pio_pkg::*;
#(
  parameter int   DEBOUNCE_CYCLES = 50000,
  parameter logic IDLE_LEVEL      = 1'b1
) (
  input  logic clk,
  input  logic reset_n,
  input  logic pin_in,
  output logic deb_out
);

  localparam int CNT_W = cnt_width(DEBOUNCE_CYCLES);

  logic sync1_q, sync1_d;
  logic sync2_q, sync2_d;

  always_comb begin
    sync1_d = pin_in;
    sync2_d = sync1_q;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1_q <= IDLE_LEVEL;
      sync2_q <= IDLE_LEVEL;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
    end
  end

  if (DEBOUNCE_CYCLES == 0) begin : g_bypass
    assign deb_out = sync2_q;
  end else begin : g_filter
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             deb_q, deb_d;

    // The counter only runs while the synchronised level disagrees with
    // the accepted level; any agreeing cycle restarts the qualification.
    always_comb begin
      cnt_d = cnt_q;
      deb_d = deb_q;
      if (sync2_q == deb_q) begin
        cnt_d = '0;
      end else if (cnt_q == CNT_LAST) begin
        deb_d = sync2_q;
        cnt_d = '0;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end

    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        cnt_q <= '0;
        deb_q <= IDLE_LEVEL;
      end else begin
        cnt_q <= cnt_d;
        deb_q <= deb_d;
      end
    end

    assign deb_out = deb_q;
  end

endmodule

// File: rtl/lab_nios_system_de2_pio_keys_in.sv
// Avalon-MM input PIO for the DE2 keys and switches.
//   clk, reset_n  system clock, asynchronous active-low reset
//   address       register select (0 data, 1 reserved, 2 irq_mask,
//                 3 edge_capture)
//   chipselect    slave select
//   write_n       active-low write strobe
//   writedata     write data; only [WIDTH-1:0] is used
//   in_port       raw asynchronous pins
//   readdata      zero-wait-state read data, zero-extended above WIDTH
//   irq           registered level interrupt, active high
// Each pin is synchronised and debounced; selected debounced edges set
// sticky capture bits that are cleared by writing ones to them.
module lab_nios_system_de2_pio_keys_in
  import lab_nios_system_pio_pkg::*;
#(
  parameter int   WIDTH           = 4,
  parameter int   DEBOUNCE_CYCLES = 50000,
  parameter int   EDGE_TYPE       = 0,
  parameter logic IDLE_LEVEL      = 1'b1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [1:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  input  logic [WIDTH-1:0] in_port,
  output logic [31:0]      readdata,
  output logic             irq
);

  logic [WIDTH-1:0] deb;
  logic [WIDTH-1:0] edges;
  logic [WIDTH-1:0] prev_q, prev_d;
  logic [WIDTH-1:0] irq_mask_q, irq_mask_d;
  logic [WIDTH-1:0] edge_cap_q, edge_cap_d;
  logic             irq_q, irq_d;
  logic             wr_en;
  logic [WIDTH-1:0] rd_bits;

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    lab_nios_system_pio_debounce #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .IDLE_LEVEL      (IDLE_LEVEL)
    ) u_debounce (
      .clk     (clk),
      .reset_n (reset_n),
      .pin_in  (in_port[i]),
      .deb_out (deb[i])
    );
  end

  if (WIDTH < 32) begin : g_wdata_hi
    logic unused_wdata_hi;
    assign unused_wdata_hi = ^writedata[31:WIDTH];
  end

  assign wr_en = chipselect && !write_n;

  always_comb begin
    if (EDGE_TYPE == EDGE_RISE) begin
      edges = ~prev_q & deb;
    end else if (EDGE_TYPE == EDGE_ANY) begin
      edges = prev_q ^ deb;
    end else begin
      edges = prev_q & ~deb;
    end
  end

  // A detected edge is OR-ed in after the clear, so a set on the same
  // cycle as a write-1-to-clear keeps the bit asserted.
  always_comb begin
    prev_d     = deb;
    irq_mask_d = irq_mask_q;
    edge_cap_d = edge_cap_q;
    if (wr_en && (address == ADDR_IRQ_MASK)) begin
      irq_mask_d = writedata[WIDTH-1:0];
    end
    if (wr_en && (address == ADDR_EDGE_CAP)) begin
      edge_cap_d = edge_cap_q & ~writedata[WIDTH-1:0];
    end
    edge_cap_d = edge_cap_d | edges;
    irq_d      = |(edge_cap_q & irq_mask_q);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      prev_q     <= {WIDTH{IDLE_LEVEL}};
      irq_mask_q <= '0;
      edge_cap_q <= '0;
      irq_q      <= 1'b0;
    end else begin
      prev_q     <= prev_d;
      irq_mask_q <= irq_mask_d;
      edge_cap_q <= edge_cap_d;
      irq_q      <= irq_d;
    end
  end

  always_comb begin
    rd_bits = '0;
    case (address)
      ADDR_DATA:     rd_bits = deb;
      ADDR_RSVD:     rd_bits = '0;
      ADDR_IRQ_MASK: rd_bits = irq_mask_q;
      ADDR_EDGE_CAP: rd_bits = edge_cap_q;
      default:       rd_bits = '0;
    endcase
    readdata = '0;
    readdata[WIDTH-1:0] = rd_bits;
  end

  assign irq = irq_q;

endmodule
